// File: rtl/substraction_if.sv
// Operand/result bundle between the expression parser and the subtraction unit.
// Latency: none (wires only).
// Backpressure: none; the parser strobes parser_done and the unit answers with a done pulse.
//
// Signals:
//   src1, src2         16-bit minuend/subtrahend from the parser
//   parser_done        operand-valid strobe; a rising edge requests one subtraction
//   substraction_done  one-cycle pulse marking a fresh calc_res
//   calc_res           32-bit two's complement difference
interface substraction_if;
  logic [15:0] src1;
  logic [15:0] src2;
  logic        parser_done;
  logic        substraction_done;
  logic [31:0] calc_res;

  // Parser side: drives operands and strobe, observes the result.
  modport master (
    output src1,
    output src2,
    output parser_done,
    input  substraction_done,
    input  calc_res
  );

  // Subtraction unit side.
  modport slave (
    input  src1,
    input  src2,
    input  parser_done,
    output substraction_done,
    output calc_res
  );
endinterface

// File: rtl/substraction.sv
// Computes src1 - src2 as a 32-bit two's complement result on each rising edge of parser_done.
// Latency: start seen at edge N, calc_res valid and substraction_done high from edge N+1, done low from N+2.
// Backpressure: none; a start edge arriving while an operation is in flight is dropped.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   n_rst  synchronous active-high reset
//   bus    substraction_if.slave (src1, src2, parser_done in; substraction_done, calc_res out)
//
// Build option: define SUB_SIGNED_EN to sign-extend the 16-bit operands; otherwise they are
// zero-extended. Nothing else depends on the macro.
module substraction (
  input  logic                 clk,
  input  logic                 n_rst,
  substraction_if.slave        bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic        parser_done_d;
  logic [15:0] op1;
  logic [15:0] op2;
  logic [31:0] res_q;
  logic        done_q;
  logic        start;
  logic [31:0] op1_ext;
  logic [31:0] op2_ext;

  // Only the 0->1 transition requests work; a held strobe never retriggers.
  assign start = bus.parser_done & ~parser_done_d;

`ifdef SUB_SIGNED_EN
  assign op1_ext = {{16{op1[15]}}, op1};
  assign op2_ext = {{16{op2[15]}}, op2};
`else
  assign op1_ext = {16'h0000, op1};
  assign op2_ext = {16'h0000, op2};
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state         <= IDLE;
      parser_done_d <= 1'b0;
      op1           <= 16'h0000;
      op2           <= 16'h0000;
      res_q         <= 32'h0000_0000;
      done_q        <= 1'b0;
    end else begin
      // Edge-detect history keeps updating even while busy, so an edge that
      // lands in CALC/DONE is consumed and cannot fire later.
      parser_done_d <= bus.parser_done;
      case (state)
        IDLE: begin
          if (start) begin
            op1   <= bus.src1;
            op2   <= bus.src2;
            state <= CALC;
          end
        end
        CALC: begin
          res_q  <= op1_ext - op2_ext;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.calc_res          = res_q;
  assign bus.substraction_done = done_q;

endmodule

// File: tb/tb_substraction.sv
module tb_substraction;

  logic clk;
  logic n_rst;
  int   total;
  int   bad;
  int   cyc;

  substraction_if bus ();

  substraction dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the outputs should be, described by behaviour
  // (when a request is accepted and when its answer appears), not by FSM states.
  logic [31:0] exp_res;
  logic        exp_done;
  logic        prev_pd;
  int          launch;      // edge index at which the last accepted request was seen
  logic [15:0] pend_a;
  logic [15:0] pend_b;

  function automatic logic [31:0] ref_diff(input logic [15:0] a, input logic [15:0] b);
    int va;
    int vb;
`ifdef SUB_SIGNED_EN
    va = int'($signed(a));
    vb = int'($signed(b));
`else
    va = int'({16'h0000, a});
    vb = int'({16'h0000, b});
`endif
    return 32'(va - vb);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, advance the model on the rising
  // edge, sample 1 time unit later and compare both outputs.
  task automatic cycle(input logic rst, input logic pd, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    n_rst           = rst;
    bus.parser_done = pd;
    bus.src1        = a;
    bus.src2        = b;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_res  = 32'h0;
      exp_done = 1'b0;
      prev_pd  = 1'b0;
      launch   = -100;
    end else begin
      exp_done = (cyc == launch + 1);
      if (cyc == launch + 1) exp_res = ref_diff(pend_a, pend_b);
      // A request occupies the unit for the edge it is seen plus two more.
      if (pd && !prev_pd && cyc >= launch + 3) begin
        launch = cyc;
        pend_a = a;
        pend_b = b;
      end
      prev_pd = pd;
    end
    #1;
    chk("done", {31'b0, bus.substraction_done}, {31'b0, exp_done});
    chk("res", bus.calc_res, exp_res);
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    exp_res = 32'h0;
    exp_done = 1'b0;
    prev_pd = 1'b0;
    launch = -100;
    pend_a = 16'h0;
    pend_b = 16'h0;
    n_rst = 1'b1;
    bus.parser_done = 1'b0;
    bus.src1 = 16'h0;
    bus.src2 = 16'h0;

    // Reset state
    cycle(1, 0, 16'h1234, 16'h5678);
    cycle(1, 1, 16'h1234, 16'h5678);
    chk("rst_res", bus.calc_res, 32'h0);

    // Start on the first cycle after reset release, 9 - 1
    cycle(0, 1, 16'h0009, 16'h0001);
    chk("r026_idle", {31'b0, bus.substraction_done}, 32'h0);
    cycle(0, 1, 16'h0009, 16'h0001);
    chk("r026_res", bus.calc_res, 32'h0000_0008);
    chk("r026_pulse", {31'b0, bus.substraction_done}, 32'h1);
    // Held high with new operands: no retrigger
    cycle(0, 1, 16'h0006, 16'h0002);
    chk("r027_pulse_end", {31'b0, bus.substraction_done}, 32'h0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 16'h0006, 16'h0002);
    chk("r027_hold", bus.calc_res, 32'h0000_0008);

    // 1 - 0xFFFF
    cycle(0, 0, 16'h0006, 16'h0002);
    cycle(0, 1, 16'h0001, 16'hFFFF);
    cycle(0, 1, 16'h3333, 16'h4444);   // later operand changes must not matter
`ifdef SUB_SIGNED_EN
    chk("r028_res", bus.calc_res, 32'h0000_0002);
`else
    chk("r028_res", bus.calc_res, 32'hFFFF_0002);
`endif
    cycle(0, 0, 16'h0, 16'h0);

    // 0x8000 - 1
    cycle(0, 0, 16'h0, 16'h0);
    cycle(0, 1, 16'h8000, 16'h0001);
    cycle(0, 0, 16'h0, 16'h0);
`ifdef SUB_SIGNED_EN
    chk("r029_res", bus.calc_res, 32'hFFFF_7FFF);
`else
    chk("r029_res", bus.calc_res, 32'h0000_7FFF);
`endif
    cycle(0, 0, 16'h0, 16'h0);

    // Reset while the subtraction is in CALC: aborted, no pulse
    cycle(0, 1, 16'h0005, 16'h0003);
    cycle(1, 1, 16'h0005, 16'h0003);
    chk("r030_res", bus.calc_res, 32'h0);
    cycle(0, 0, 16'h0, 16'h0);
    chk("r030_nopulse", {31'b0, bus.substraction_done}, 32'h0);
    cycle(0, 0, 16'h0, 16'h0);

    // Second edge during DONE is dropped, later edge in IDLE works
    cycle(0, 1, 16'd20, 16'd5);
    cycle(0, 0, 16'd0, 16'd0);
    chk("r031_first", bus.calc_res, 32'd15);
    cycle(0, 1, 16'd100, 16'd1);
    cycle(0, 0, 16'd0, 16'd0);
    chk("r031_dropped", {31'b0, bus.substraction_done}, 32'h0);
    cycle(0, 0, 16'd0, 16'd0);
    chk("r031_keep", bus.calc_res, 32'd15);
    cycle(0, 1, 16'd7, 16'd3);
    cycle(0, 1, 16'd0, 16'd0);
    chk("r031_again", bus.calc_res, 32'd4);

    // Randomized traffic against the model
    begin
      logic pd;
      pd = 1'b1;
      for (int i = 0; i < 600; i++) begin
        logic rst;
        rst = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 2) == 0) pd = ~pd;
        cycle(rst, pd, 16'($urandom), 16'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case the clock or a task stalls
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/substraction.md
SUBSTRACTION -- requirements
Module: substraction

Interface
REQ-001 The module SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  reset, synchronous and active-high; it is sampled on the clk rising edge.
REQ-004 src1  input  16  minuend operand from the parser.
REQ-005 src2  input  16  subtrahend operand from the parser.
REQ-006 parser_done  input  1  operand-valid strobe from the parser; a 0->1 transition requests one subtraction.
REQ-007 substraction_done  output  1  single-cycle pulse marking a new result on calc_res.
REQ-008 calc_res  output  32  registered result src1 - src2, in 32-bit two's complement.

Function
REQ-009 The module SHALL register parser_done into parser_done_d every cycle and detect a start when parser_done=1 and parser_done_d=0.
REQ-010 The FSM SHALL have three states: IDLE, CALC and DONE; it resets to IDLE.
REQ-011 IDLE: on a start, the module SHALL capture src1/src2 into internal operand registers and go to CALC; otherwise it stays in IDLE.
REQ-012 CALC: the module SHALL write calc_res = ext(op1) - ext(op2), computed at 32 bits, set substraction_done=1 and go to DONE.
REQ-013 DONE: the module SHALL clear substraction_done and go to IDLE.
REQ-014 Latency SHALL be fixed: start detected at edge N; calc_res valid and substraction_done high from edge N+1; substraction_done low again from edge N+2.
REQ-015 substraction_done SHALL be high for exactly one cycle per start.
REQ-016 calc_res SHALL hold its last value until the next CALC or reset.
REQ-017 Holding parser_done high SHALL NOT retrigger; operand changes while it stays high SHALL be ignored.
REQ-018 A start edge arriving while in CALC or DONE SHALL be dropped; parser_done_d still updates every cycle.
REQ-019 Operands are captured at the start edge only; later src1/src2 changes SHALL NOT affect the pending result.
REQ-020 ext() SHALL zero-extend 16->32 by default; see REQ-025 for the alternative.
REQ-021 Any negative difference SHALL appear as 32-bit two's complement (1-2 -> 0xFFFFFFFF). No overflow is possible, so no flag exists.

Reset
REQ-022 While n_rst=1 at a clk edge, the module SHALL set: FSM=IDLE, calc_res=0, substraction_done=0, operand registers=0, parser_done_d=0.
REQ-023 Reset mid-operation (CALC or DONE) SHALL abort the operation with no done pulse.
REQ-024 If parser_done is high on the first cycle after reset release, that cycle SHALL count as a start (parser_done_d was reset to 0).

Configuration
REQ-025 Macro SUB_SIGNED_EN:
- Defined: ext() sign-extends src1/src2 as signed 16-bit values.
- Undefined: ext() zero-extends them as unsigned values.
- No other behaviour changes in either case.

Verification
REQ-026 Reset, then parser_done 0->1 with src1=0x0009, src2=0x0001 -> one cycle later calc_res=0x00000008, substraction_done pulses for exactly 1 cycle.
REQ-027 Keep parser_done high and change to src1=0x0006, src2=0x0002 -> no new pulse; calc_res stays 0x00000008.
REQ-028 Drop and re-raise parser_done with src1=0x0001, src2=0xFFFF:
- SUB_SIGNED_EN undefined -> calc_res=0xFFFF0002.
- SUB_SIGNED_EN defined -> calc_res=0x00000002.
REQ-029 Start with src1=0x8000, src2=0x0001:
- Unsigned -> calc_res=0x00007FFF.
- Signed -> calc_res=0xFFFF7FFF.
REQ-030 Assert n_rst during CALC -> calc_res=0; no substraction_done pulse; FSM in IDLE.
REQ-031 Second 0->1 edge of parser_done during DONE -> ignored; exactly one pulse; a later edge in IDLE computes normally.
